ahb_lite_initiator: RTL
=======================

// Module: ahb_lite_initiator
// PURPOSE
//  Single-clock AHB-Lite initiator (bus master). Turns a valid/ready command stream into
//  pipelined single-word NONSEQ transfers to an AHB-Lite responder such as the GPIO peripheral.
//  Returns a one-cycle response pulse per completed transfer, carrying read data for reads.
//  Replaces behavioural bus driving in benches and lets on-chip logic program peripherals.
// PARAMETERS
//  ADDR_W  32  HADDR / cmd_addr width
//  DATA_W  32  HWDATA / HRDATA / cmd_wdata / rsp_rdata width
// PORTS
//  HCLK       in   1       clock, all logic on rising edge
//  HRESET     in   1       synchronous reset, active-high
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted on edge where cmd_valid & cmd_ready
//  cmd_write  in   1       1 = write, 0 = read
//  cmd_addr   in   ADDR_W  byte address (word-aligned by caller)
//  cmd_wdata  in   DATA_W  write data
//  HSEL       out  1       responder select
//  HADDR      out  ADDR_W  address-phase address
//  HTRANS     out  2       2'b00 IDLE, 2'b10 NONSEQ (no other codes issued)
//  HWRITE     out  1       address-phase direction
//  HSIZE      out  3       fixed 3'b010 (word)
//  HWDATA     out  DATA_W  data-phase write data
//  HREADY     in   1       bus ready (responder HREADYOUT)
//  HRDATA     in   DATA_W  read data, valid in final data-phase cycle
//  rsp_valid  out  1       one-cycle pulse per completed transfer, no backpressure
//  rsp_write  out  1       direction of completed transfer
//  rsp_rdata  out  DATA_W  captured HRDATA for reads; 0 for writes
//  busy       out  1       any transfer in address or data phase
// BEHAVIOUR
//  - Two-stage pipeline: address stage (a_vld, a_write, a_addr, a_wdata) and data stage
//    (d_vld, d_write, d_wdata). Up to 2 transfers in flight.
//  - cmd_ready = HREADY (combinational). The responder stalls both stages; no command is
//    accepted while HREADY = 0.
//  - Stage registers advance only on edges with HREADY = 1:
//    d_* <= a_*; a_vld <= cmd_valid; a_* <= cmd_*.
//  - Address-stage outputs: HTRANS = a_vld ? 2'b10 : 2'b00; HSEL = a_vld.
//    HADDR = a_addr and HWRITE = a_write, held across wait states.
//  - When idle, HADDR and HWRITE keep their last value.
//  - HWDATA = d_wdata, held stable through data-phase wait states.
//  - Completion edge: d_vld & HREADY. On the next cycle rsp_valid = 1 and rsp_write = d_write.
//    rsp_rdata = d_write ? 0 : HRDATA sampled at that edge. Otherwise rsp_valid = 0.
//  - Latency with zero wait states: acceptance edge E0; NONSEQ driven in cycle after E0;
//    data phase after E1; completion at E2; rsp_valid high in cycle after E2.
//    Each wait state adds one cycle.
//  - Throughput: back-to-back commands with HREADY = 1 yield one transfer per cycle.
//    Responses arrive in command order.
//  - busy = a_vld | d_vld.
//  - Wait state during an idle address stage: a pending data phase holds, HTRANS stays IDLE.
//  - Reset (HRESET = 1 at an edge), including mid-transfer:
//    - a_vld = d_vld = 0; HTRANS = 00; HSEL = 0; HADDR = 0; HWRITE = 0; HWDATA = 0;
//      rsp_valid = 0; rsp_write = 0; rsp_rdata = 0.
//    - In-flight transfers are dropped with no response.
//    - cmd_ready still follows HREADY, but nothing is captured while HRESET = 1.
//  - No error response: HRESP is not part of the bus.
// TESTING
//  Bench: responder model with programmable wait states, plus GPIO peripheral integration.
//  1 Write A=0x0000_0000 D=0xA5A5 (0 waits) -> NONSEQ/HWRITE=1 for 1 cycle;
//    HWDATA=0xA5A5 next cycle; rsp_valid with rsp_write=1 three cycles after accept.
//  2 Read A=0x4 with responder returning 0x1234, 0 waits -> rsp_valid, rsp_write=0,
//    rsp_rdata=0x1234 three cycles after accept.
//  3 Write then read issued back-to-back, 2 wait states on the write data phase ->
//    - read address phase held 2 extra cycles, HWDATA stable throughout;
//    - responses in order, read rsp 2 cycles later than unstalled.
//  4 Stream of 8 commands, HREADY=1 -> cmd_ready high throughout; 8 consecutive rsp_valid
//    pulses; HTRANS=10 for 8 consecutive cycles.
//  5 HRESET asserted while one transfer is in address phase and one in data phase ->
//    next cycle HTRANS=00, HSEL=0, busy=0; no rsp_valid for either transfer.
//  6 GPIO loopback: write 0x00C3 to the GPIO output register, then read the input register
//    -> rsp_rdata[15:0]=0x00C3 and the loopback checker error stays 0.

Source files
------------

// File: rtl/ahb_lite_initiator.sv
// ahb_lite_initiator
//   AHB-Lite bus master. Accepts a valid/ready command stream and issues
//   pipelined single-word NONSEQ transfers. Each completed transfer produces
//   a one-cycle response pulse; for reads it carries the captured HRDATA.
//
// Ports
//   HCLK, HRESET            clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (cmd_ready mirrors HREADY)
//   cmd_write/addr/wdata    command direction, byte address, write data
//   HSEL/HADDR/HTRANS/
//   HWRITE/HSIZE/HWDATA     AHB-Lite master outputs
//   HREADY/HRDATA           AHB-Lite responder inputs
//   rsp_valid/write/rdata   completion pulse, direction and read data
//   busy                    a transfer sits in the address or data phase
module ahb_lite_initiator #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HRDATA,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // Address stage
    logic              a_vld_r;
    logic              a_write_r;
    logic [ADDR_W-1:0] a_addr_r;
    logic [DATA_W-1:0] a_wdata_r;
    // Data stage
    logic              d_vld_r;
    logic              d_write_r;
    logic [DATA_W-1:0] d_wdata_r;
    // Response
    logic              rsp_valid_r;
    logic              rsp_write_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    // Address stage: loads a new command on every ready edge. Address, direction
    // and data are only overwritten by a real command so HADDR/HWRITE hold when idle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_vld_r   <= 1'b0;
            a_write_r <= 1'b0;
            a_addr_r  <= {ADDR_W{1'b0}};
            a_wdata_r <= {DATA_W{1'b0}};
        end else if (HREADY) begin
            a_vld_r <= cmd_valid;
            if (cmd_valid) begin
                a_write_r <= cmd_write;
                a_addr_r  <= cmd_addr;
                a_wdata_r <= cmd_wdata;
            end
        end
    end

    // Data stage: takes over the address-stage transfer on a ready edge; the
    // write data stays put through wait states and idle cycles.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            d_vld_r   <= 1'b0;
            d_write_r <= 1'b0;
            d_wdata_r <= {DATA_W{1'b0}};
        end else if (HREADY) begin
            d_vld_r <= a_vld_r;
            if (a_vld_r) begin
                d_write_r <= a_write_r;
                d_wdata_r <= a_wdata_r;
            end
        end
    end

    // Response: a data phase completes on a ready edge; pulse for one cycle and
    // capture read data (writes report zero). Reset drops in-flight transfers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else if (HREADY && d_vld_r) begin
            rsp_valid_r <= 1'b1;
            rsp_write_r <= d_write_r;
            rsp_rdata_r <= d_write_r ? {DATA_W{1'b0}} : HRDATA;
        end else begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Bus-facing outputs decoded from the stage registers.
    always_comb begin
        cmd_ready = HREADY;
        HSEL      = a_vld_r;
        HADDR     = a_addr_r;
        HWRITE    = a_write_r;
        HSIZE     = HSIZE_WORD;
        HWDATA    = d_wdata_r;
        rsp_valid = rsp_valid_r;
        rsp_write = rsp_write_r;
        rsp_rdata = rsp_rdata_r;
        busy      = a_vld_r | d_vld_r;
        if (a_vld_r) begin
            HTRANS = HTRANS_NONSEQ;
        end else begin
            HTRANS = HTRANS_IDLE;
        end
    end

endmodule
